// File: rtl/operand_stage.sv
// Operand fetch stage: register file, write-back bypass, busy-bit
// scoreboard and a one-entry output register toward the ALU.
module operand_stage #(
  parameter int n             = 8,
  parameter int alu_code_size = 3,
  parameter int r             = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [r-1:0]             rs_addr,
  input  logic [r-1:0]             rt_addr,
  input  logic [r-1:0]             rd_addr,
  input  logic [n-1:0]             imm,
  input  logic                     use_imm,
  input  logic [alu_code_size-1:0] func_in,
  input  logic                     we_in,
  input  logic                     wb_en,
  input  logic [r-1:0]             wb_addr,
  input  logic [n-1:0]             wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [n-1:0]      a,
  output logic signed [n-1:0]      b,
  output logic [alu_code_size-1:0] func,
  output logic [r-1:0]             out_rd,
  output logic                     out_we
);

  localparam int nr = 2 ** r;

  logic [n-1:0]  rf [nr];
  logic [nr-1:0] busy;
  logic [nr-1:0] busy_nxt;

  logic [n-1:0]  rs_val;
  logic [n-1:0]  rt_val;
  logic [n-1:0]  b_val;

  logic          rs_wb_hit;
  logic          rt_wb_hit;
  logic          rs_haz;
  logic          rt_haz;
  logic          slot_free;
  logic          xfer_in;
  logic          xfer_out;

  assign rs_wb_hit = wb_en && (wb_addr == rs_addr);
  assign rt_wb_hit = wb_en && (wb_addr == rt_addr);

  always_comb begin
    rs_val = rf[rs_addr];
    if (rs_addr == '0)
      rs_val = '0;
    else if (rs_wb_hit)
      rs_val = wb_data;
  end

  always_comb begin
    rt_val = rf[rt_addr];
    if (rt_addr == '0)
      rt_val = '0;
    else if (rt_wb_hit)
      rt_val = wb_data;
  end

  assign b_val = use_imm ? imm : rt_val;

  // A source waits on a retired-but-unwritten result (busy) or on the
  // instruction still sitting in the output register.
  always_comb begin
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    if (rs_addr != '0) begin
      rs_haz = (busy[rs_addr] && !rs_wb_hit)
            || (out_valid && out_we && (out_rd == rs_addr));
    end
    if (!use_imm && (rt_addr != '0)) begin
      rt_haz = (busy[rt_addr] && !rt_wb_hit)
            || (out_valid && out_we && (out_rd == rt_addr));
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = reset || (slot_free && !rs_haz && !rt_haz);
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;

  // Clear first so a same-address set in the same cycle wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)
      busy_nxt[wb_addr] = 1'b0;
    if (xfer_out && out_we && (out_rd != '0))
      busy_nxt[out_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < nr; i++)
        rf[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      func      <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      a         <= rs_val;
      b         <= b_val;
      func      <= func_in;
      out_rd    <= rd_addr;
      out_we    <= we_in;
    end else if (xfer_out) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios plus a scoreboard of
// expected ALU operand bundles checked on every output transfer.
module tb_operand_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] rs_addr, rt_addr, rd_addr;
  logic [7:0] imm;
  logic       use_imm;
  logic [2:0] func_in;
  logic       we_in;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       out_valid;
  logic       out_ready;
  logic signed [7:0] a, b;
  logic [2:0] func;
  logic [2:0] out_rd;
  logic       out_we;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] f;
    logic [2:0] rd;
    logic       we;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  exp_t       got;
  logic [7:0] mreg [8];

  always #5 clk = ~clk;

  operand_stage #(.n(8), .alu_code_size(3), .r(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .imm(imm), .use_imm(use_imm), .func_in(func_in), .we_in(we_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .func(func), .out_rd(out_rd), .out_we(out_we)
  );

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mreg[i] <= 8'h00;
    end else if (wb_en && wb_addr != 3'd0) begin
      mreg[wb_addr] <= wb_data;
    end
  end

  function automatic logic [7:0] src_val(input logic [2:0] ad);
    if (ad == 3'd0) return 8'h00;
    if (wb_en && wb_addr == ad) return wb_data;
    return mreg[ad];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: output transfer with nothing expected");
        end else begin
          e = q.pop_front();
          got = '{a: a, b: b, f: func, rd: out_rd, we: out_we};
          if (got !== e) begin
            n_fail++;
            $display("FAIL sb_bundle: got a=%h b=%h f=%0d rd=%0d we=%b expected a=%h b=%h f=%0d rd=%0d we=%b",
                     a, b, func, out_rd, out_we, e.a, e.b, e.f, e.rd, e.we);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.a  = src_val(rs_addr);
        e.b  = use_imm ? imm : src_val(rt_addr);
        e.f  = func_in;
        e.rd = rd_addr;
        e.we = we_in;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; wb_en = 0; out_ready = 1; use_imm = 0; we_in = 0;
    imm = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0; func_in = 0;
    wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic [2:0] f,
                       input logic w, input logic ui, input logic [7:0] im);
    in_valid = 1; rs_addr = rs; rt_addr = rt; rd_addr = rd;
    func_in = f; we_in = w; use_imm = ui; imm = im;
  endtask

  task automatic wb(input logic [2:0] ad, input logic [7:0] d);
    wb_en = 1; wb_addr = ad; wb_data = d;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    tick(); tick(); samp();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if ({a, b, func, out_rd, out_we} !== 23'd0) begin n_fail++; $display("FAIL rst_fields: got a=%h b=%h f=%0d rd=%0d we=%b expected all 0", a, b, func, out_rd, out_we); end
    n_checks++; if (dut.busy !== 8'h00) begin n_fail++; $display("FAIL rst_busy: got %h expected 00", dut.busy); end
    tick();
    reset = 0;
  endtask

  task automatic test_rs_bypass();
    idle(); wb(3'd5, 8'h12);
    tick();
    wb_en = 0; issue(3'd5, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00);
    samp();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rd_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 0;
    samp();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rd_latency: got out_valid=%b expected 1", out_valid); end
    n_checks++; if (a !== 8'sh12 || b !== 8'sh00) begin n_fail++; $display("FAIL rd_ops: got a=%h b=%h expected a=12 b=00", a, b); end
    tick(); samp();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_hazard();
    idle(); issue(3'd1, 3'd2, 3'd3, 3'd0, 1'b1, 1'b0, 8'h00);
    tick();
    issue(3'd3, 3'd0, 3'd0, 3'd1, 1'b0, 1'b1, 8'h05);
    samp();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hz_inflight: got in_ready=%b expected 0", in_ready); end
    tick();
    for (int i = 0; i < 3; i++) begin
      samp();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hz_busy[%0d]: got in_ready=%b expected 0", i, in_ready); end
      tick();
    end
    wb(3'd3, 8'h40);
    samp();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hz_release: got in_ready=%b expected 1", in_ready); end
    tick();
    wb_en = 0; in_valid = 0;
    samp();
    n_checks++; if (out_valid !== 1'b1 || a !== 8'sh40) begin n_fail++; $display("FAIL hz_bypass: got v=%b a=%h expected v=1 a=40", out_valid, a); end
    n_checks++; if (dut.busy !== 8'h00) begin n_fail++; $display("FAIL hz_busy_clr: got %h expected 00", dut.busy); end
    tick();
  endtask

  task automatic test_stall();
    idle(); out_ready = 0;
    issue(3'd5, 3'd3, 3'd0, 3'd2, 1'b0, 1'b0, 8'h00);
    tick();
    issue(3'd3, 3'd5, 3'd0, 3'd4, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      samp();
      n_checks++; if (out_valid !== 1'b1 || a !== 8'sh12 || b !== 8'sh40 || func !== 3'd2) begin n_fail++; $display("FAIL st_hold[%0d]: got v=%b a=%h b=%h f=%0d expected v=1 a=12 b=40 f=2", i, out_valid, a, b, func); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL st_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
    end
    out_ready = 1;
    samp();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL st_resume: got in_ready=%b expected 1", in_ready); end
    tick();
    in_valid = 0;
    samp();
    n_checks++; if (out_valid !== 1'b1 || a !== 8'sh40 || b !== 8'sh12 || func !== 3'd4) begin n_fail++; $display("FAIL st_b2b: got v=%b a=%h b=%h f=%0d expected v=1 a=40 b=12 f=4", out_valid, a, b, func); end
    tick();
  endtask

  task automatic test_imm();
    idle(); issue(3'd0, 3'd0, 3'd2, 3'd0, 1'b1, 1'b0, 8'h00);
    tick();
    issue(3'd0, 3'd2, 3'd0, 3'd3, 1'b0, 1'b0, 8'h00);
    samp();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL im_rt_inflight: got in_ready=%b expected 0", in_ready); end
    tick(); samp();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL im_rt_busy: got in_ready=%b expected 0", in_ready); end
    tick();
    issue(3'd5, 3'd2, 3'd0, 3'd3, 1'b0, 1'b1, 8'h80);
    samp();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL im_nostall: got in_ready=%b expected 1", in_ready); end
    tick();
    in_valid = 0;
    samp();
    n_checks++; if (b !== -8'sd128 || a !== 8'sh12) begin n_fail++; $display("FAIL im_value: got a=%h b=%0d expected a=12 b=-128", a, b); end
    tick();
    wb(3'd2, 8'h07);
    tick();
    idle();
  endtask

  task automatic test_zero();
    idle(); wb(3'd0, 8'hFF);
    tick();
    wb_en = 0; issue(3'd0, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 8'h00);
    tick();
    in_valid = 0;
    samp();
    n_checks++; if (a !== 8'sh00 || b !== 8'sh00) begin n_fail++; $display("FAIL z_read: got a=%h b=%h expected 00 00", a, b); end
    tick();
    issue(3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 8'h00);
    tick();
    in_valid = 0;
    tick(); samp();
    n_checks++; if (dut.busy !== 8'h00) begin n_fail++; $display("FAIL z_busy: got %h expected 00", dut.busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 6; i++) begin
      issue(3'(i), 3'(7 - i), 3'(i), 3'(i), 1'b0, 1'b0, 8'h00);
      samp();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bb_ready[%0d]: got %b expected 1", i, in_ready); end
      if (i > 0) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bb_valid[%0d]: got %b expected 1", i, out_valid); end
      end
      tick();
    end
    in_valid = 0;
    samp();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bb_last: got %b expected 1", out_valid); end
    tick(); samp();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bb_empty: got %b expected 0", out_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle(); issue(3'd0, 3'd0, 3'd4, 3'd0, 1'b1, 1'b0, 8'h00);
    tick();
    issue(3'd0, 3'd0, 3'd6, 3'd0, 1'b1, 1'b0, 8'h00);
    tick();
    in_valid = 0; out_ready = 0;
    samp();
    n_checks++; if (dut.busy !== 8'h10 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_setup: got busy=%h v=%b expected busy=10 v=1", dut.busy, out_valid); end
    tick();
    reset = 1;
    samp();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b expected 1", in_ready); end
    tick();
    reset = 0; idle();
    samp();
    n_checks++; if (out_valid !== 1'b0 || dut.busy !== 8'h00) begin n_fail++; $display("FAIL rm_clear: got v=%b busy=%h expected v=0 busy=00", out_valid, dut.busy); end
    tick();
    issue(3'd3, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00);
    tick();
    in_valid = 0;
    samp();
    n_checks++; if (a !== 8'sh00 || b !== 8'sh00) begin n_fail++; $display("FAIL rm_regs: got a=%h b=%h expected 00 00", a, b); end
    tick();
  endtask

  initial begin
    test_reset();
    test_rs_bypass();
    test_hazard();
    test_stall();
    test_imm();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    tick();
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending expected 0", q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The module SHALL have parameter n, default 8: data width, matching the ALU operand width.
REQ-002 The module SHALL have parameter alu_code_size, default 3: ALU function code width.
REQ-003 The module SHALL have parameter r, default 3: register address width, giving 2**r registers.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have ports in_valid (input, 1) and in_ready (output, 1): the issue handshake.
REQ-007 The module SHALL have ports rs_addr, rt_addr and rd_addr, each input, r bits: source and destination register addresses.
REQ-008 The module SHALL have ports imm (input, n), use_imm (input, 1), func_in (input, alu_code_size) and we_in (input, 1): immediate value, B-operand select, ALU function, and instruction-writes-back flag.
REQ-009 The module SHALL have ports wb_en (input, 1), wb_addr (input, r) and wb_data (input, n): ALU result write-back port.
REQ-010 The module SHALL have ports out_valid (output, 1) and out_ready (input, 1): the handshake toward the ALU.
REQ-011 The module SHALL have ports a and b, each output, n bits, signed: registered ALU operands.
REQ-012 The module SHALL have ports func (output, alu_code_size), out_rd (output, r) and out_we (output, 1): registered instruction fields.

Function
REQ-013 The register file SHALL hold 2**r registers of n bits; register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-014 When wb_en=1 and wb_addr!=0, the module SHALL write wb_data to register wb_addr at the clock edge.
REQ-015 The module SHALL read both sources combinationally; if wb_en=1 and wb_addr equals a nonzero source address, it SHALL bypass wb_data to that source in the same cycle.
REQ-016 The B source SHALL be imm when use_imm=1, and the bypassed rt value otherwise.
REQ-017 The scoreboard SHALL be a 2**r-bit busy vector; bit k SHALL set on an output transfer (out_valid and out_ready) with out_we=1 and out_rd=k!=0.
REQ-018 Busy bit k SHALL clear on wb_en=1 with wb_addr=k; if set and clear coincide on the same k, set SHALL win.
REQ-019 A source SHALL be hazardous when its address is nonzero and either (a) its busy bit is 1 and wb_en is not writing that address this cycle, or (b) out_valid=1, out_we=1 and out_rd equals that address.
REQ-020 rt SHALL be checked for hazards only when use_imm=0.
REQ-021 in_ready SHALL be (out_valid=0 or out_ready=1) and no source is hazardous.
REQ-022 On an input transfer (in_valid and in_ready), a, b, func, out_rd and out_we SHALL load at the edge, and out_valid SHALL be 1 the next cycle; latency is 1 cycle.
REQ-023 On an output transfer with no input transfer, out_valid SHALL clear; without out_ready, all outputs SHALL hold stable.
REQ-024 in_ready SHALL not depend on in_valid; in_valid may drop without a transfer.
REQ-025 A simultaneous input and output transfer SHALL reload the register, keeping out_valid=1, and SHALL sustain one instruction per cycle.

Reset
REQ-026 When reset=1 at an edge, all registers, the busy vector, out_valid, a, b, func, out_rd and out_we SHALL become 0; reset SHALL take priority over every write and transfer.
REQ-027 While reset=1, in_ready SHALL be 1.
REQ-028 Reset mid-operation SHALL discard any held instruction and all pending scoreboard entries.

Verification
REQ-029 Reset, then write-back 5<-0x12 and issue rs=5, rt=0, func=ADD -> one cycle later out_valid=1, a=0x12, b=0.
REQ-030 Issue with we_in=1, rd=3 while out_ready=1, then issue rs=3 -> in_ready=0 until wb_en with wb_addr=3 and wb_data=0x40; in that same cycle in_ready=1 and the next a=0x40 (bypass).
REQ-031 Hold out_ready=0 with out_valid=1 for 4 cycles -> a, b and func are unchanged and in_ready=0; raise out_ready together with in_valid -> back-to-back transfer with out_valid staying 1.
REQ-032 use_imm=1, imm=0x80, with rt busy -> no stall, b=0x80 (signed -128).
REQ-033 Write-back to register 0 with 0xFF, then read rs=0 -> a=0; an issue with rd=0 and we_in=1 -> busy vector unchanged.
REQ-034 Assert reset with out_valid=1 and busy bits set -> next cycle out_valid=0, busy vector=0, all registers read 0.
